// File: rtl/load_store_unit.sv
// RV32I data-memory stage: sizes/aligns core loads and stores onto a valid/ready word bus.
// Latency 2 stall cycles at zero wait (fault: 1); waits on mem_ready up to TIMEOUT cycles while holding the core via stall.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [29:0]       waddr_q, waddr_d;
    logic              we_q, we_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    logic              fault;
    logic [3:0]        st_strb;
    logic [31:0]       st_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_ext;

    // Request decode: funct3[1:0] is the size, funct3[2] the unsigned flag (loads only).
    always_comb begin
        fault = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                (req_write && req_funct3[2]) ||
                (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        case (req_funct3[1:0])
            2'b00: begin
                st_data = {4{req_wdata[7:0]}};
                st_strb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_data = {2{req_wdata[15:0]}};
                st_strb = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = req_wdata;
                st_strb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        waddr_d  = waddr_q;
        we_d     = we_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        berr_d   = berr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    berr_d = 1'b0;
                    if (fault) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d  = BUS;
                        mis_d    = 1'b0;
                        waddr_d  = req_addr[31:2];
                        we_d     = req_write;
                        wstrb_d  = req_write ? st_strb : 4'b0000;
                        wdata_d  = req_write ? st_data : 32'd0;
                        funct3_d = req_funct3;
                        off_d    = req_addr[1:0];
                    end
                end
            end
            BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // mem_ready takes priority over a timeout landing in the same cycle
                if (mem_ready) begin
                    state_d = DONE;
                    rdata_d = we_q ? 32'd0 : ld_ext;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DONE;
                    berr_d  = 1'b1;
                    rdata_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            waddr_q  <= '0;
            we_q     <= 1'b0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            off_q    <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            waddr_q  <= waddr_d;
            we_q     <= we_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    assign stall      = req_valid && (state_q != DONE);
    assign resp_valid = (state_q == DONE);
    assign misaligned = resp_valid && mis_q;
    assign bus_err    = resp_valid && berr_q;
    assign rdata      = rdata_q;
    assign mem_valid  = (state_q == BUS);
    assign mem_we     = mem_valid && we_q;
    assign mem_addr   = mem_valid ? {waddr_q, 2'b00} : 32'd0;
    assign mem_wstrb  = mem_valid ? wstrb_q : 4'b0000;
    assign mem_wdata  = mem_valid ? wdata_q : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses against an arithmetic reference model.
module tb_load_store_unit;
    localparam int TMO = 16;

    logic        clk;
    logic        reset, req_valid, req_write, mem_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        stall, resp_valid, misaligned, bus_err, mem_valid, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          stall_cycles;
        int          mv_cycles;
        int          resp_cycle;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mwstrb;
        logic        mwe;
        bit          unstable;
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
    } obs_t;

    typedef struct {
        bit          fault;
        bit          berr;
        int          mv_cycles;
        int          resp_cycle;
        logic [31:0] maddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .rdata(rdata), .misaligned(misaligned),
        .bus_err(bus_err), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what one access should look like on the bus and at the response.
    function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rd, input int ready_at,
                                  output exp_t e);
        int size, sh, strb;
        logic [31:0] mask, v, w;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        sh = int'(addr % 4);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        e.fault = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3[2]) || (addr % size != 0);
        e.maddr = addr & ~32'h3;
        strb = ((1 << size) - 1) << sh;
        e.wstrb = wr ? strb[3:0] : 4'b0000;
        w = 32'd0;
        for (int i = 0; i < 4 / size; i++) w = w | ((wd & mask) << (i * 8 * size));
        e.wdata = wr ? w : 32'd0;
        if (e.fault) begin
            e.berr = 0; e.mv_cycles = 0; e.resp_cycle = 2; e.rdata = 32'd0;
        end else begin
            e.berr = (ready_at < 0) || (ready_at >= TMO);
            e.mv_cycles = e.berr ? TMO : ready_at + 1;
            e.resp_cycle = e.mv_cycles + 2;
            v = (rd >> (8 * sh)) & mask;
            if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
            e.rdata = e.berr ? 32'd0 : v;
        end
    endfunction

    // Drives one request from the IDLE cycle; memory asserts mem_ready on bus cycle ready_at (-1 = never).
    task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int ready_at,
                              output obs_t o);
        int bidx;
        bit done;
        o.stall_cycles = 0; o.mv_cycles = 0; o.resp_cycle = 0; o.unstable = 0;
        o.maddr = '0; o.mwdata = '0; o.mwstrb = '0; o.mwe = 1'b0;
        o.rdata = '0; o.mis = 1'b0; o.berr = 1'b0;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_rdata = rd;
        bidx = 0;
        done = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            if (mem_valid === 1'b1) begin
                if (bidx == 0) begin
                    o.maddr = mem_addr; o.mwdata = mem_wdata; o.mwstrb = mem_wstrb; o.mwe = mem_we;
                end else if (o.maddr !== mem_addr || o.mwdata !== mem_wdata ||
                             o.mwstrb !== mem_wstrb || o.mwe !== mem_we) begin
                    o.unstable = 1;
                end
                mem_ready = (bidx == ready_at);
                bidx++;
                o.mv_cycles++;
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (stall === 1'b1) o.stall_cycles++;
            if (resp_valid === 1'b1) begin
                o.resp_cycle = cyc; o.rdata = rdata; o.mis = misaligned; o.berr = bus_err;
                done = 1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({stall, resp_valid, misaligned, bus_err, mem_valid, mem_we, mem_wstrb} !== 10'd0)
            $display("FAIL reset_ctrl: got %b want 0", {stall, resp_valid, misaligned, bus_err, mem_valid, mem_we, mem_wstrb}); else passes++;
        checks++; if ({rdata, mem_addr, mem_wdata} !== 96'd0)
            $display("FAIL reset_data: got %h want 0", {rdata, mem_addr, mem_wdata}); else passes++;
        req_valid = 1'b1; #1;
        checks++; if (stall !== 1'b1) $display("FAIL reset_stall_follows_req: got %b want 1", stall); else passes++;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        obs_t o;
        run_access(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, 32'd0, 0, o);
        checks++; if (o.maddr !== 32'h08) $display("FAIL sw_addr: got %h want 00000008", o.maddr); else passes++;
        checks++; if (o.mwstrb !== 4'b1111) $display("FAIL sw_wstrb: got %b want 1111", o.mwstrb); else passes++;
        checks++; if (o.mwe !== 1'b1) $display("FAIL sw_we: got %b want 1", o.mwe); else passes++;
        checks++; if (o.mwdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata: got %h want deadbeef", o.mwdata); else passes++;
        checks++; if (o.stall_cycles !== 2) $display("FAIL sw_stall: got %0d want 2", o.stall_cycles); else passes++;
        checks++; if (o.resp_cycle !== 3) $display("FAIL sw_resp_cycle: got %0d want 3", o.resp_cycle); else passes++;
        checks++; if ({o.mis, o.berr} !== 2'b00) $display("FAIL sw_faults: got %b want 00", {o.mis, o.berr}); else passes++;
    endtask

    task automatic test_load_ext();
        obs_t o;
        run_access(1'b0, 3'b000, 32'h05, 32'd0, 32'h0000_8000, 0, o);
        checks++; if (o.rdata !== 32'hFFFF_FF80) $display("FAIL lb_sext: got %h want ffffff80", o.rdata); else passes++;
        checks++; if ({o.mwe, o.mwstrb} !== 5'd0) $display("FAIL lb_we_strb: got %b want 00000", {o.mwe, o.mwstrb}); else passes++;
        run_access(1'b0, 3'b100, 32'h05, 32'd0, 32'h0000_8000, 2, o);
        checks++; if (o.rdata !== 32'h0000_0080) $display("FAIL lbu_zext: got %h want 00000080", o.rdata); else passes++;
        checks++; if (o.resp_cycle !== 5) $display("FAIL lbu_wait_resp: got %0d want 5", o.resp_cycle); else passes++;
        run_access(1'b0, 3'b101, 32'h06, 32'd0, 32'hBEEF_0000, 0, o);
        checks++; if (o.rdata !== 32'h0000_BEEF) $display("FAIL lhu_zext: got %h want 0000beef", o.rdata); else passes++;
        run_access(1'b0, 3'b001, 32'h06, 32'd0, 32'hBEEF_0000, 0, o);
        checks++; if (o.rdata !== 32'hFFFF_BEEF) $display("FAIL lh_sext: got %h want ffffbeef", o.rdata); else passes++;
    endtask

    task automatic test_store_half_byte();
        obs_t o;
        run_access(1'b1, 3'b001, 32'h06, 32'h0000_1234, 32'd0, 0, o);
        checks++; if (o.mwdata !== 32'h1234_1234) $display("FAIL sh_wdata: got %h want 12341234", o.mwdata); else passes++;
        checks++; if (o.mwstrb !== 4'b1100) $display("FAIL sh_wstrb: got %b want 1100", o.mwstrb); else passes++;
        checks++; if (o.maddr !== 32'h04) $display("FAIL sh_addr: got %h want 00000004", o.maddr); else passes++;
        run_access(1'b1, 3'b000, 32'h07, 32'h0000_00AB, 32'd0, 1, o);
        checks++; if (o.mwdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata: got %h want abababab", o.mwdata); else passes++;
        checks++; if (o.mwstrb !== 4'b1000) $display("FAIL sb_wstrb: got %b want 1000", o.mwstrb); else passes++;
        checks++; if (o.unstable !== 1'b0) $display("FAIL sb_bus_stable: got %b want 0", o.unstable); else passes++;
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_access(1'b0, 3'b010, 32'h02, 32'd0, 32'hFFFF_FFFF, 0, o);
        checks++; if (o.mis !== 1'b1) $display("FAIL lw_mis_flag: got %b want 1", o.mis); else passes++;
        checks++; if (o.resp_cycle !== 2) $display("FAIL lw_mis_resp: got %0d want 2", o.resp_cycle); else passes++;
        checks++; if (o.mv_cycles !== 0) $display("FAIL lw_mis_no_bus: got %0d want 0", o.mv_cycles); else passes++;
        checks++; if (o.rdata !== 32'd0) $display("FAIL lw_mis_rdata: got %h want 0", o.rdata); else passes++;
        run_access(1'b0, 3'b011, 32'h00, 32'd0, 32'd0, 0, o);
        checks++; if ({o.mis, o.resp_cycle[3:0], o.mv_cycles[3:0]} !== 9'b1_0010_0000)
            $display("FAIL f3_011_fault: got mis=%b resp=%0d bus=%0d want 1/2/0", o.mis, o.resp_cycle, o.mv_cycles); else passes++;
        run_access(1'b1, 3'b100, 32'h00, 32'd0, 32'd0, 0, o);
        checks++; if (o.mis !== 1'b1) $display("FAIL store_unsigned_fault: got %b want 1", o.mis); else passes++;
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1'b0, 3'b010, 32'h10, 32'd0, 32'hCAFE_F00D, TMO - 1, o);
        checks++; if (o.mv_cycles !== TMO) $display("FAIL late_ready_bus: got %0d want %0d", o.mv_cycles, TMO); else passes++;
        checks++; if ({o.berr, o.mis} !== 2'b00) $display("FAIL late_ready_faults: got %b want 00", {o.berr, o.mis}); else passes++;
        checks++; if (o.rdata !== 32'hCAFE_F00D) $display("FAIL late_ready_rdata: got %h want cafef00d", o.rdata); else passes++;
        run_access(1'b0, 3'b010, 32'h10, 32'd0, 32'h1111_1111, -1, o);
        checks++; if (o.mv_cycles !== TMO) $display("FAIL tmo_bus_cycles: got %0d want %0d", o.mv_cycles, TMO); else passes++;
        checks++; if (o.berr !== 1'b1) $display("FAIL tmo_bus_err: got %b want 1", o.berr); else passes++;
        checks++; if (o.rdata !== 32'd0) $display("FAIL tmo_rdata: got %h want 0", o.rdata); else passes++;
        checks++; if (o.resp_cycle !== TMO + 2) $display("FAIL tmo_resp_cycle: got %0d want %0d", o.resp_cycle, TMO + 2); else passes++;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        run_access(1'b1, 3'b010, 32'h40, 32'h0BAD_F00D, 32'd0, 0, o1);
        run_access(1'b0, 3'b010, 32'h44, 32'd0, 32'h7654_3210, 0, o2);
        checks++; if (o1.resp_cycle !== 3) $display("FAIL b2b_first_resp: got %0d want 3", o1.resp_cycle); else passes++;
        checks++; if (o2.resp_cycle !== 3) $display("FAIL b2b_second_resp: got %0d want 3", o2.resp_cycle); else passes++;
        checks++; if (o2.rdata !== 32'h7654_3210) $display("FAIL b2b_rdata: got %h want 76543210", o2.rdata); else passes++;
        checks++; if (o2.maddr !== 32'h44) $display("FAIL b2b_addr: got %h want 00000044", o2.maddr); else passes++;
    endtask

    task automatic test_reset_mid_bus();
        obs_t o;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; mem_ready = 1'b0;
        mem_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (mem_valid !== 1'b1) $display("FAIL rst_mid_in_bus: got %b want 1", mem_valid); else passes++;
        req_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({mem_valid, stall, resp_valid, misaligned, bus_err, mem_we, mem_wstrb} !== 10'd0)
            $display("FAIL rst_mid_ctrl: got %b want 0", {mem_valid, stall, resp_valid, misaligned, bus_err, mem_we, mem_wstrb}); else passes++;
        checks++; if ({rdata, mem_addr, mem_wdata} !== 96'd0)
            $display("FAIL rst_mid_data: got %h want 0", {rdata, mem_addr, mem_wdata}); else passes++;
        reset = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({resp_valid, mem_valid} !== 2'b00) $display("FAIL rst_late_ready: got %b want 00", {resp_valid, mem_valid}); else passes++;
        mem_ready = 1'b0;
        run_access(1'b0, 3'b010, 32'h0, 32'd0, 32'h1234_5678, 1, o);
        checks++; if (o.rdata !== 32'h1234_5678) $display("FAIL rst_after_lw_rdata: got %h want 12345678", o.rdata); else passes++;
        checks++; if (o.resp_cycle !== 4) $display("FAIL rst_after_lw_resp: got %0d want 4", o.resp_cycle); else passes++;
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic wr;
        logic [2:0] f3;
        logic [31:0] addr, wd, rd;
        int r, ready_at;
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wd = $urandom;
            rd = $urandom;
            r = int'($urandom_range(0, 9));
            ready_at = (r == 0) ? -1 : (r == 1) ? TMO - 1 : r - 2;
            model(wr, f3, addr, wd, rd, ready_at, e);
            run_access(wr, f3, addr, wd, rd, ready_at, o);
            checks++; if (o.mis !== e.fault) $display("FAIL rnd_mis[%0d]: got %b want %b", n, o.mis, e.fault); else passes++;
            checks++; if (o.berr !== e.berr) $display("FAIL rnd_berr[%0d]: got %b want %b", n, o.berr, e.berr); else passes++;
            checks++; if (o.resp_cycle !== e.resp_cycle) $display("FAIL rnd_resp[%0d]: got %0d want %0d", n, o.resp_cycle, e.resp_cycle); else passes++;
            checks++; if (o.mv_cycles !== e.mv_cycles) $display("FAIL rnd_bus_cycles[%0d]: got %0d want %0d", n, o.mv_cycles, e.mv_cycles); else passes++;
            checks++; if (o.stall_cycles !== e.resp_cycle - 1) $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, o.stall_cycles, e.resp_cycle - 1); else passes++;
            if (!e.fault) begin
                checks++; if ({o.maddr, o.mwe, o.mwstrb, o.mwdata} !== {e.maddr, wr, e.wstrb, e.wdata})
                    $display("FAIL rnd_bus[%0d]: got %h/%b/%b/%h want %h/%b/%b/%h", n, o.maddr, o.mwe, o.mwstrb, o.mwdata, e.maddr, wr, e.wstrb, e.wdata); else passes++;
                checks++; if (o.unstable !== 1'b0) $display("FAIL rnd_stable[%0d]: got %b want 0", n, o.unstable); else passes++;
            end
            if (!wr || e.fault) begin
                checks++; if (o.rdata !== e.rdata) $display("FAIL rnd_rdata[%0d]: got %h want %h", n, o.rdata, e.rdata); else passes++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        test_reset();
        test_store_word();
        test_load_ext();
        test_store_half_byte();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_bus();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "watchdog");
    end
endmodule
